debounce_event_arbiter: RTL and testbench

Multi-channel switch front end. It synchronises and debounces NUM_SW raw switch inputs against one shared prescaled sample tick, and turns each confirmed level change into an event. Events from all channels are arbitrated round-robin onto a single valid/ready event port. The block sits between the board buttons and the core's memory-mapped input logic, and replaces per-switch debounce counters running at full clock rate.

---
 rtl/debounce_event_arbiter.sv | 156 +++++++++++++++
 tb/tb_debounce_event_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_event_arbiter.sv
// Debounces NUM_SW async switches on a shared prescaled tick; arbitrates edge events round-robin onto one valid/ready port.
// Latency: 2-cycle synchroniser + STABLE_TICKS ticks to confirm a level; the event register loads the cycle after confirmation.
// Backpressure: event held stable while !i_Evt_Ready; one pending edge per channel, and overwriting it sets o_Overflow. Option: DEBOUNCE_RELEASE_EVT_EN.
module debounce_event_arbiter #(
    parameter int NUM_SW       = 4,
    parameter int CH_W         = 2,
    parameter int TICK_DIV     = 25000,
    parameter int STABLE_TICKS = 10
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic [NUM_SW-1:0] i_Switch,
    output logic [NUM_SW-1:0] o_Level,
    output logic              o_Evt_Valid,
    input  logic              i_Evt_Ready,
    output logic [CH_W-1:0]   o_Evt_Ch,
    output logic              o_Evt_Press,
    output logic              o_Overflow,
    input  logic              i_Clr_Overflow
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0] CNT_LAST = 8'(STABLE_TICKS - 1);

    logic [NUM_SW-1:0] sync1_q, sync_q;
    logic [PW-1:0]     pre_q;
    logic              tick;
    logic [7:0]        cnt_q [NUM_SW];
    logic [NUM_SW-1:0] confirm, edge_evt;
    logic [NUM_SW-1:0] pend_q, pend_d;
    logic [CH_W-1:0]   rr_q;
    logic              slot_free, grant_vld, grant, ovf_set;
    logic [CH_W-1:0]   grant_ch;

    assign tick      = (pre_q == PRE_LAST);
    assign slot_free = !o_Evt_Valid || i_Evt_Ready;
    assign grant     = slot_free && grant_vld;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync1_q <= '0;
            sync_q  <= '0;
            pre_q   <= '0;
        end else begin
            sync1_q <= i_Switch;
            sync_q  <= sync1_q;
            pre_q   <= tick ? '0 : pre_q + 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Level <= '0;
            for (int i = 0; i < NUM_SW; i++) cnt_q[i] <= '0;
        end else if (tick) begin
            for (int i = 0; i < NUM_SW; i++) begin
                if (sync_q[i] == o_Level[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    o_Level[i] <= sync_q[i];
                    cnt_q[i]   <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        confirm = '0;
        for (int i = 0; i < NUM_SW; i++)
            confirm[i] = tick && (sync_q[i] != o_Level[i]) && (cnt_q[i] == CNT_LAST);
    end

`ifdef DEBOUNCE_RELEASE_EVT_EN
    assign edge_evt = confirm;
`else
    assign edge_evt = confirm & sync_q;
`endif

    // Round-robin search starts one past the last granted channel.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_ch  = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_SW; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_SW) idx = idx - NUM_SW;
            for (int j = 0; j < NUM_SW; j++) begin
                if (!grant_vld && (j == idx) && pend_q[j]) begin
                    grant_vld = 1'b1;
                    grant_ch  = CH_W'(j);
                end
            end
        end
    end

    // A grant frees its pend bit before a same-cycle edge refills it, so that case is not an overwrite.
    always_comb begin
        pend_d  = pend_q;
        ovf_set = 1'b0;
        for (int i = 0; i < NUM_SW; i++) begin
            if (grant && (grant_ch == CH_W'(i))) pend_d[i] = 1'b0;
            if (edge_evt[i]) begin
                if (pend_d[i]) ovf_set = 1'b1;
                pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            pend_q      <= '0;
            rr_q        <= '0;
            o_Evt_Valid <= 1'b0;
            o_Evt_Ch    <= '0;
            o_Overflow  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (slot_free) o_Evt_Valid <= grant_vld;
            if (grant) begin
                o_Evt_Ch <= grant_ch;
                rr_q     <= grant_ch;
            end
            if (ovf_set) o_Overflow <= 1'b1;
            else if (i_Clr_Overflow) o_Overflow <= 1'b0;
        end
    end

`ifdef DEBOUNCE_RELEASE_EVT_EN
    logic [NUM_SW-1:0] pol_q;
    logic              grant_pol;

    always_comb begin
        grant_pol = 1'b0;
        for (int j = 0; j < NUM_SW; j++)
            if (grant_ch == CH_W'(j)) grant_pol = pol_q[j];
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            pol_q       <= '0;
            o_Evt_Press <= 1'b0;
        end else begin
            if (grant) o_Evt_Press <= grant_pol;
            for (int i = 0; i < NUM_SW; i++)
                if (edge_evt[i]) pol_q[i] <= sync_q[i];
        end
    end
`else
    assign o_Evt_Press = 1'b1;
`endif

endmodule

// File: tb/tb_debounce_event_arbiter.sv
// Randomised and directed bench for debounce_event_arbiter against a tick-level behavioural model.
module tb_debounce_event_arbiter;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int ST = 3;
`ifdef DEBOUNCE_RELEASE_EVT_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw = '0;
    logic       ready = 1'b1;
    logic       clr = 1'b0;
    logic [3:0] level;
    logic       vld;
    logic [1:0] ch;
    logic       press;
    logic       ovf;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    logic [3:0] m_s1, m_s2, m_lvl, m_pend, m_pol;
    int         m_pre;
    int         m_run [4];
    logic       m_vld, m_press, m_ovf;
    logic [1:0] m_ch;
    int         m_rr;

    debounce_event_arbiter #(.NUM_SW(N), .CH_W(2), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Switch(sw), .o_Level(level),
        .o_Evt_Valid(vld), .i_Evt_Ready(ready), .o_Evt_Ch(ch), .o_Evt_Press(press),
        .o_Overflow(ovf), .i_Clr_Overflow(clr)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pend = '0; m_pol = '0;
        m_pre = 0; m_vld = 1'b0; m_press = !REL; m_ovf = 1'b0; m_ch = '0; m_rr = 0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
    endtask

    // One clock of the behavioural model: a level is accepted after ST consecutive ticks that disagree with it.
    task automatic model_update(input logic [3:0] swv, input logic rdy, input logic clrv);
        logic [3:0] s, ev, evpol;
        logic       tk;
        int         c;
        s = m_s2; ev = '0; evpol = '0;
        tk = (m_pre == TD - 1);
        for (int i = 0; i < N; i++) begin
            if (tk) begin
                if (s[i] == m_lvl[i]) m_run[i] = 0;
                else begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == ST) begin
                        m_run[i] = 0;
                        m_lvl[i] = s[i];
                        if (REL || s[i]) begin ev[i] = 1'b1; evpol[i] = s[i]; end
                    end
                end
            end
        end
        if (!m_vld || rdy) begin
            m_vld = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (m_rr + k) % N;
                if (!m_vld && m_pend[c]) begin
                    m_vld = 1'b1; m_ch = 2'(c); m_press = m_pol[c]; m_pend[c] = 1'b0; m_rr = c;
                end
            end
        end
        if (clrv) m_ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (ev[i]) begin
                if (m_pend[i]) m_ovf = 1'b1;
                m_pend[i] = 1'b1; m_pol[i] = evpol[i];
            end
        end
        m_pre = tk ? 0 : m_pre + 1;
        m_s2 = m_s1; m_s1 = swv;
    endtask

    task automatic step();
        logic [3:0] swv;
        logic       rdy, clrv;
        swv = sw; rdy = ready; clrv = clr;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_update(swv, rdy, clrv);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sw = '0; ready = 1'b1; clr = 1'b0;
        do_reset();
        n_cmp++; if (level !== 4'b0) begin n_err++; $display("FAIL reset_level got=%b exp=0000", level); end
        n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", vld); end
        n_cmp++; if (ch !== 2'd0) begin n_err++; $display("FAIL reset_ch got=%0d exp=0", ch); end
        n_cmp++; if (press !== !REL) begin n_err++; $display("FAIL reset_press got=%b exp=%b", press, !REL); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_clean_press();
        int n;
        sw = '0; ready = 1'b1;
        do_reset();
        repeat (5) step();
        sw[2] = 1'b1;
        n = 0;
        while (!level[2] && n < 30) begin step(); n++; end
        n_cmp++; if (n < 11 || n > 15) begin n_err++; $display("FAIL press_latency got=%0d cycles exp=11..15", n); end
        step();
        n_cmp++; if (vld !== 1'b1 || ch !== 2'd2 || press !== 1'b1) begin
            n_err++; $display("FAIL press_event got vld=%b ch=%0d press=%b exp 1/2/1", vld, ch, press); end
        step();
        n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL press_single got vld=%b exp=0", vld); end
    endtask

    task automatic test_bounce();
        int bad;
        sw = '0; ready = 1'b1; bad = 0;
        do_reset();
        repeat (3) step();
        for (int c = 0; c < 40; c++) begin
            if (c % 3 == 0) sw[0] = ~sw[0];
            step();
            if (level[0] !== 1'b0 || vld !== 1'b0) bad++;
        end
        sw[0] = 1'b0;
        repeat (20) begin step(); if (level[0] !== 1'b0 || vld !== 1'b0) bad++; end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL bounce got %0d bad cycles exp=0", bad); end
    endtask

    task automatic test_arbitration();
        int n;
        sw = '0;
        do_reset();
        ready = 1'b0;
        sw = 4'b1011;
        n = 0;
        while (!vld && n < 30) begin step(); n++; end
        n_cmp++; if (vld !== 1'b1 || ch !== 2'd1) begin n_err++; $display("FAIL arb_first got vld=%b ch=%0d exp 1/1", vld, ch); end
        repeat (3) step();
        n_cmp++; if (vld !== 1'b1 || ch !== 2'd1) begin n_err++; $display("FAIL arb_hold got vld=%b ch=%0d exp 1/1", vld, ch); end
        ready = 1'b1;
        step();
        n_cmp++; if (vld !== 1'b1 || ch !== 2'd3) begin n_err++; $display("FAIL arb_second got vld=%b ch=%0d exp 1/3", vld, ch); end
        step();
        n_cmp++; if (vld !== 1'b1 || ch !== 2'd0) begin n_err++; $display("FAIL arb_third got vld=%b ch=%0d exp 1/0", vld, ch); end
        step();
        n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL arb_drain got vld=%b exp=0", vld); end
    endtask

    task automatic test_overflow();
        sw = '0;
        do_reset();
        ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            sw[1] = (t % 2 == 0);
            repeat (20) step();
        end
        n_cmp++; if (vld !== 1'b1 || ch !== 2'd1 || press !== 1'b1) begin
            n_err++; $display("FAIL ovf_hold got vld=%b ch=%0d press=%b exp 1/1/1", vld, ch, press); end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set got=%b exp=1", ovf); end
        clr = 1'b1; step(); clr = 1'b0;
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
        ready = 1'b1; step();
        n_cmp++; if (vld !== 1'b1 || ch !== 2'd1 || press !== 1'b1) begin
            n_err++; $display("FAIL ovf_pending got vld=%b ch=%0d press=%b exp 1/1/1", vld, ch, press); end
        repeat (3) step();
    endtask

    task automatic test_async_reset();
        int n;
        sw = '0;
        do_reset();
        ready = 1'b0;
        sw[0] = 1'b1;
        n = 0;
        while (!vld && n < 30) begin step(); n++; end
        sw[1] = 1'b1;
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++; if (vld !== 1'b0 || level !== 4'b0 || ovf !== 1'b0 || ch !== 2'd0) begin
            n_err++; $display("FAIL async_reset got vld=%b lvl=%b ovf=%b ch=%0d exp all 0", vld, level, ovf, ch); end
        sw = 4'b1000; ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
        n = 0;
        while (!vld && n < 30) begin step(); n++; end
        n_cmp++; if (n < 12 || n > 16 || ch !== 2'd3 || press !== 1'b1) begin
            n_err++; $display("FAIL post_reset_evt got cycles=%0d ch=%0d press=%b exp 12..16/3/1", n, ch, press); end
    endtask

    task automatic test_release_filter();
        int evs, presses;
        sw = '0; ready = 1'b1; evs = 0; presses = 0;
        do_reset();
        sw[2] = 1'b1;
        repeat (25) begin step(); if (vld) begin evs++; if (press) presses++; end end
        sw[2] = 1'b0;
        repeat (25) begin step(); if (vld) begin evs++; if (press) presses++; end end
        n_cmp++; if (evs != (REL ? 2 : 1) || presses != 1) begin
            n_err++; $display("FAIL release_filter got events=%0d presses=%0d exp %0d/1", evs, presses, REL ? 2 : 1); end
        n_cmp++; if (level[2] !== 1'b0) begin n_err++; $display("FAIL release_level got=%b exp=0", level[2]); end
    endtask

    task automatic test_random();
        logic stall;
        sw = '0; clr = 1'b0; stall = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 250 == 0) stall = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 49) == 0) sw[i] = ~sw[i];
            if ($urandom_range(0, 299) == 0) sw = 4'($urandom);
            ready = stall ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 39) == 0);
            step();
            n_cmp++;
            if (level !== m_lvl || vld !== m_vld || ovf !== m_ovf ||
                (m_vld && (ch !== m_ch || press !== m_press))) begin
                n_err++;
                $display("FAIL random cyc=%0d got lvl=%b vld=%b ch=%0d press=%b ovf=%b exp lvl=%b vld=%b ch=%0d press=%b ovf=%b",
                         cyc, level, vld, ch, press, ovf, m_lvl, m_vld, m_ch, m_press, m_ovf);
            end
        end
        clr = 1'b0; ready = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_arbitration();
        test_overflow();
        test_async_reset();
        test_release_filter();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
